// File: rtl/clock_alarm.sv
// Free-running counter with NUM_ALARMS wrap-safe compare channels, a STATUS/IRQ_MASK pair
// and a single-cycle-ack wishbone register port.
//
// Alarm channel FSM (one instance per compare channel):
//   state | meaning
//   IDLE  | channel disarmed, never fires
//   ARMED | fires once the counter has reached COMPARE[n], then drops back to IDLE
module clock_alarm #(
  parameter int WIDTH      = 32,
  parameter int NUM_ALARMS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic [WIDTH-1:0]      counter,
  output logic [NUM_ALARMS-1:0] alarm_pulse,
  output logic                  irq
);

  typedef enum logic {IDLE, ARMED} alarm_state_e;

  localparam logic [3:0] ADR_COUNTER = 4'd0;
  localparam logic [3:0] ADR_CTRL    = 4'd1;
  localparam logic [3:0] ADR_STATUS  = 4'd2;
  localparam logic [3:0] ADR_MASK    = 4'd3;

  logic                  req;
  logic                  wr;
  logic                  count_en;
  logic [NUM_ALARMS-1:0] status_q;
  logic [NUM_ALARMS-1:0] irq_mask_q;
  logic [NUM_ALARMS-1:0] status_clr;
  logic [NUM_ALARMS-1:0] arm;
  logic [NUM_ALARMS-1:0] fire;
  logic [WIDTH-1:0]      cmp_q [NUM_ALARMS];
  alarm_state_e          state_q [NUM_ALARMS];
  alarm_state_e          state_d [NUM_ALARMS];
  logic [31:0]           rd_data;
  logic                  unused_dat;

  assign req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr  = req & wb_we_i;

  // Upper write-data bits are dropped when WIDTH or NUM_ALARMS is narrower than the bus.
  assign unused_dat = ^wb_dat_i;

  always_comb begin
    arm        = '0;
    status_clr = '0;
    if (wr && wb_adr_i == ADR_STATUS) status_clr = wb_dat_i[NUM_ALARMS-1:0];
    for (int n = 0; n < NUM_ALARMS; n++) begin
      if (wr && wb_adr_i == 4'(n + 4)) arm[n] = 1'b1;
    end
  end

  // "Reached" is the MSB of the modular difference being clear, which stays correct across wrap.
  always_comb begin
    for (int n = 0; n < NUM_ALARMS; n++) begin
      state_d[n] = state_q[n];
      fire[n]    = 1'b0;
      case (state_q[n])
        IDLE: begin
          if (arm[n]) state_d[n] = ARMED;
        end
        ARMED: begin
          if (((counter - cmp_q[n]) >> (WIDTH - 1)) == '0) begin
            fire[n]    = 1'b1;
            state_d[n] = IDLE;
          end
          if (arm[n]) state_d[n] = ARMED;
        end
        default: state_d[n] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_ALARMS; n++) begin
      if (rst) state_q[n] <= IDLE;
      else     state_q[n] <= state_d[n];
    end
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_COUNTER: rd_data[WIDTH-1:0]      = counter;
      ADR_CTRL:    rd_data[0]              = count_en;
      ADR_STATUS:  rd_data[NUM_ALARMS-1:0] = status_q;
      ADR_MASK:    rd_data[NUM_ALARMS-1:0] = irq_mask_q;
      default: begin
        for (int n = 0; n < NUM_ALARMS; n++) begin
          if (wb_adr_i == 4'(n + 4)) rd_data[WIDTH-1:0] = cmp_q[n];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      counter     <= '0;
      count_en    <= 1'b1;
      status_q    <= '0;
      irq_mask_q  <= '0;
      alarm_pulse <= '0;
      irq         <= 1'b0;
      for (int n = 0; n < NUM_ALARMS; n++) cmp_q[n] <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd_data : '0;

      if (wr && wb_adr_i == ADR_COUNTER) counter <= wb_dat_i[WIDTH-1:0];
      else if (count_en)                 counter <= counter + WIDTH'(1);

      if (wr && wb_adr_i == ADR_CTRL) count_en   <= wb_dat_i[0];
      if (wr && wb_adr_i == ADR_MASK) irq_mask_q <= wb_dat_i[NUM_ALARMS-1:0];

      // A fire in the same cycle as a write-1-to-clear keeps the bit set.
      status_q    <= (status_q & ~status_clr) | fire;
      alarm_pulse <= fire;
      irq         <= |(status_q & irq_mask_q);

      for (int n = 0; n < NUM_ALARMS; n++) begin
        if (arm[n]) cmp_q[n] <= wb_dat_i[WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/clock_alarm.md
CLOCK_ALARM -- requirements
Module: clock_alarm

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter width in bits (8..32).
REQ-002 SHALL have parameter NUM_ALARMS, default 4, number of compare channels (1..8).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wb_stb_i  input  1  wishbone strobe.
REQ-006 SHALL have port wb_cyc_i  input  1  wishbone cycle.
REQ-007 SHALL have port wb_we_i  input  1  wishbone write enable.
REQ-008 SHALL have port wb_adr_i  input  4  wishbone word address.
REQ-009 SHALL have port wb_dat_i  input  32  wishbone write data.
REQ-010 SHALL have port wb_dat_o  output  32  wishbone read data.
REQ-011 SHALL have port wb_ack_o  output  1  wishbone acknowledge.
REQ-012 SHALL have port counter  output  WIDTH  free-running clock count.
REQ-013 SHALL have port alarm_pulse  output  NUM_ALARMS  one-cycle pulse per alarm fire.
REQ-014 SHALL have port irq  output  1  level interrupt request.

Function
REQ-015 Register map (word address): 0 COUNTER r/w; 1 CTRL (bit0 count enable) r/w; 2 STATUS (bit n = alarm n fired) read / write-1-to-clear; 3 IRQ_MASK r/w; 4+n COMPARE[n] r/w for n < NUM_ALARMS.
REQ-016 Bus request = wb_stb_i & wb_cyc_i & !wb_ack_o; wb_ack_o SHALL be registered, high exactly one cycle, in the cycle after a request.
REQ-017 Writes SHALL take effect on the edge that asserts wb_ack_o; wb_dat_o SHALL be valid in the wb_ack_o cycle and zero otherwise.
REQ-018 Unmapped addresses (including COMPARE slots n >= NUM_ALARMS) SHALL be acked, read as zero, and writes ignored.
REQ-019 Values narrower than 32 bits SHALL read zero-extended; writes SHALL use the low bits only.
REQ-020 Counter SHALL increment by 1 each cycle while CTRL bit0 = 1, wrapping from 2^WIDTH-1 to 0.
REQ-021 A COUNTER write SHALL load wb_dat_i into the counter, taking priority over that cycle's increment.
REQ-022 Each alarm SHALL have states IDLE and ARMED; a COMPARE[n] write SHALL load the value and enter ARMED (re-arming if already ARMED).
REQ-023 ARMED alarm n SHALL fire when the MSB of (counter - COMPARE[n]) modulo 2^WIDTH is 0, i.e. wrap-safe "counter has reached compare".
REQ-024 On fire: next cycle alarm_pulse[n] = 1 for one cycle, STATUS[n] set, alarm returns to IDLE; an IDLE alarm SHALL never fire.
REQ-025 Compare uses the registered counter value; a COMPARE write arming an already-past value SHALL fire on the first evaluation after arming (pulse 2 cycles after the write-ack edge).
REQ-026 If a STATUS set and a write-1-to-clear for the same bit occur in the same cycle, set SHALL win.
REQ-027 irq SHALL be registered: irq = OR over n of (STATUS[n] & IRQ_MASK[n]), one cycle after STATUS/IRQ_MASK change.
REQ-028 Alarm firing SHALL continue while CTRL bit0 = 0 (counter frozen) if the condition holds.
REQ-029 Multiple alarms firing in the same cycle SHALL each pulse and set their own STATUS bit.

Reset
REQ-030 When rst = 1: counter = 0, CTRL = 1, STATUS = 0, IRQ_MASK = 0, all COMPARE = 0, all alarms IDLE, alarm_pulse = 0, irq = 0, wb_ack_o = 0, wb_dat_o = 0.
REQ-031 Reset mid-transaction SHALL drop any pending ack and discard the write; counting resumes the first cycle after rst deasserts.

Verification
REQ-032 Release reset, idle 10 cycles, read COUNTER -> value in the ack cycle equals the cycle count since reset release; wb_ack_o high exactly 1 cycle.
REQ-033 Write IRQ_MASK=0x1, COMPARE[0]=counter+20 -> alarm_pulse[0] one cycle at counter match, STATUS=0x1, irq=1; write STATUS=0x1 -> irq=0 next cycle.
REQ-034 WIDTH=8: write COUNTER=0xF0, COMPARE[1]=0x10 -> alarm fires after wrap at counter 0x10, not earlier; COUNTER reads 0x000000xx.
REQ-035 Write COMPARE[2] to counter-5 (past) -> pulse 2 cycles after ack; write CTRL=0 then COUNTER=0x100 -> counter holds 0x100.
REQ-036 Force alarm 0 fire coincident with STATUS W1C of bit 0 -> STATUS[0]=1 afterwards; read address 0xF -> 0, acked.
REQ-037 Assert rst during a write cycle to COMPARE[0] -> no ack, COMPARE[0]=0, alarm IDLE, all outputs at REQ-030 values.
